// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace buffer: state encoding and the
// bit layout of one captured entry {pc_addr, opcode, ir_addr, data}.
package cpu_trace_pkg;

  // Capture state encoding (matches the 2-bit state output)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Total width of one trace entry
  function automatic int entry_width(input int addr_w, input int op_w, input int data_w);
    return 2 * addr_w + op_w + data_w;
  endfunction

  // Field LSB offsets; data sits in the LSBs, pc_addr in the MSBs
  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int ir_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int op_lsb(input int addr_w, input int data_w);
    return data_w + addr_w;
  endfunction

  function automatic int pc_lsb(input int addr_w, input int op_w, input int data_w);
    return data_w + addr_w + op_w;
  endfunction

endpackage

// File: rtl/trace_mem.sv
// Trace storage: DEPTH x WIDTH register file, one synchronous write port
// and one asynchronous read port. Contents are not reset; validity is
// tracked by the owner through its pointer and count.
module trace_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 37,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write one entry on a capture
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/trace_buffer.sv
// CPU instruction trace buffer: records one entry per fetch rising edge
// while armed, fires on a halt edge or opcode match, keeps POST_N more
// captures, then presents the ring oldest-first for readout.
module trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 16,
  parameter int POST_N = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            arm,
  input  logic                            trig_op_en,
  input  logic [OP_W-1:0]                 trig_op,
  input  logic                            fetch,
  input  logic [ADDR_W-1:0]               pc_addr,
  input  logic [ADDR_W-1:0]               ir_addr,
  input  logic [OP_W-1:0]                 opcode,
  input  logic [DATA_W-1:0]               data,
  input  logic                            halt,
  input  logic                            rd_ready,
  output logic                            rd_valid,
  output logic [2*ADDR_W+OP_W+DATA_W-1:0] rd_entry,
  output logic [$clog2(DEPTH):0]          count,
  output logic                            overflow,
  output logic [1:0]                      state
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = entry_width(ADDR_W, OP_W, DATA_W);
  localparam int PC_LSB  = pc_lsb(ADDR_W, OP_W, DATA_W);
  localparam int OP_LSB  = op_lsb(ADDR_W, DATA_W);
  localparam int IR_LSB  = ir_lsb(DATA_W);
  localparam int DT_LSB  = data_lsb();

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] POST_C  = CNT_W'(POST_N);

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] post_q, post_d;
  logic             fetch_q, fetch_d;
  logic             halt_q, halt_d;

  logic               capture_s;
  logic               op_hit_s;
  logic               halt_rise_s;
  logic               rd_valid_s;
  logic               mem_we_s;
  logic [PTR_W-1:0]   rd_addr_s;
  logic [ENTRY_W-1:0] wdata_s;

  // Pack the current input samples into one entry word
  always_comb begin
    wdata_s = '0;
    wdata_s[PC_LSB +: ADDR_W] = pc_addr;
    wdata_s[OP_LSB +: OP_W]   = opcode;
    wdata_s[IR_LSB +: ADDR_W] = ir_addr;
    wdata_s[DT_LSB +: DATA_W] = data;
  end

  // Next-state logic: arm clears everything; otherwise capture, trigger and pop
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    post_d     = post_q;
    fetch_d    = fetch;
    halt_d     = halt;
    mem_we_s   = 1'b0;

    halt_rise_s = halt & ~halt_q;
    capture_s   = fetch & ~fetch_q & ((state_q == ST_ARMED) || (state_q == ST_POST));
    op_hit_s    = trig_op_en & (opcode == trig_op);
    rd_valid_s  = (state_q == ST_DONE) && (count_q != '0);
    rd_addr_s   = wr_ptr_q - count_q[PTR_W-1:0];

    if (arm) begin
      state_d    = ST_ARMED;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      post_d     = '0;
    end else begin
      // A capture at full depth overwrites the oldest entry and keeps count
      if (capture_s) begin
        mem_we_s = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (count_q == DEPTH_C) begin
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end else begin
        mem_we_s = 1'b0;
      end

      case (state_q)
        ST_ARMED: begin
          // Trigger-cycle capture is kept and does not consume a post slot
          if (halt_rise_s || (capture_s && op_hit_s)) begin
            post_d  = POST_C;
            state_d = (POST_N == 0) ? ST_DONE : ST_POST;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_POST: begin
          if (capture_s) begin
            post_d  = post_q - CNT_W'(1);
            state_d = (post_q == CNT_W'(1)) ? ST_DONE : ST_POST;
          end else begin
            state_d = ST_POST;
          end
        end
        ST_DONE: begin
          if (rd_valid_s && rd_ready) begin
            count_d = count_q - CNT_W'(1);
          end else begin
            count_d = count_q;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      post_q     <= '0;
      fetch_q    <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      post_q     <= post_d;
      fetch_q    <= fetch_d;
      halt_q     <= halt_d;
    end
  end

  trace_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_ptr_q),
    .wdata (wdata_s),
    .raddr (rd_addr_s),
    .rdata (rd_entry)
  );

  assign rd_valid = rd_valid_s;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer with DEPTH=4, POST_N=2.
module tb_trace_buffer;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int OW = 3;
  localparam int EW = 2 * AW + OW + DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          arm = 1'b0;
  logic          trig_op_en = 1'b0;
  logic [OW-1:0] trig_op = 3'd0;
  logic          fetch = 1'b0;
  logic [AW-1:0] pc_addr = 13'd0;
  logic [AW-1:0] ir_addr = 13'd0;
  logic [OW-1:0] opcode = 3'd0;
  logic [DW-1:0] data = 8'd0;
  logic          halt = 1'b0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [EW-1:0] rd_entry;
  logic [2:0]    count;
  logic          overflow;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] expq [4];

  trace_buffer #(
    .ADDR_W (AW), .DATA_W (DW), .OP_W (OW), .DEPTH (4), .POST_N (2)
  ) dut (
    .clk (clk), .reset (reset), .arm (arm), .trig_op_en (trig_op_en),
    .trig_op (trig_op), .fetch (fetch), .pc_addr (pc_addr), .ir_addr (ir_addr),
    .opcode (opcode), .data (data), .halt (halt), .rd_ready (rd_ready),
    .rd_valid (rd_valid), .rd_entry (rd_entry), .count (count),
    .overflow (overflow), .state (state)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk(input logic [AW-1:0] pc, input logic [OW-1:0] op,
                                       input logic [AW-1:0] ir, input logic [DW-1:0] d);
    return {pc, op, ir, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [AW-1:0] pc, input logic [OW-1:0] op,
                          input logic [AW-1:0] ir, input logic [DW-1:0] d);
    pc_addr = pc; opcode = op; ir_addr = ir; data = d;
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    step();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic halt_edge();
    halt = 1'b1;
    step();
    halt = 1'b0;
    step();
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_state", 64'(state), 64'(2'd0));
    chk("rst_count", 64'(count), 64'(3'd0));
    chk("rst_ovf", 64'(overflow), 64'(1'b0));
    chk("rst_rdv", 64'(rd_valid), 64'(1'b0));
    step();
    reset = 1'b0;
    step();
    chk("idle_hold", 64'(state), 64'(2'd0));

    // Wrap-around with halt trigger: 3 pre, halt, 2 post into a 4-deep ring
    do_arm();
    chk("armed", 64'(state), 64'(2'd1));
    for (int i = 0; i < 3; i++) begin
      do_fetch(13'(16'h100 + i), 3'(i + 2), 13'(16'h200 + i), 8'(8'hA0 + i));
    end
    chk("pre_count", 64'(count), 64'(3'd3));
    chk("pre_rdv", 64'(rd_valid), 64'(1'b0));
    halt_edge();
    chk("halt_post", 64'(state), 64'(2'd2));
    for (int i = 3; i < 5; i++) begin
      do_fetch(13'(16'h100 + i), 3'(i + 2), 13'(16'h200 + i), 8'(8'hA0 + i));
    end
    chk("wrap_state", 64'(state), 64'(2'd3));
    chk("wrap_count", 64'(count), 64'(3'd4));
    chk("wrap_ovf", 64'(overflow), 64'(1'b1));
    // Oldest surviving entry is the second capture
    for (int i = 0; i < 4; i++) begin
      expq[i] = mk(13'(16'h101 + i), 3'(i + 3), 13'(16'h201 + i), 8'(8'hA1 + i));
    end
    // Streaming readout: one pop per cycle, oldest first
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rd_valid_stream", 64'(rd_valid), 64'(1'b1));
      chk("rd_entry_stream", 64'(rd_entry), 64'(expq[i]));
      step();
    end
    chk("drain_rdv", 64'(rd_valid), 64'(1'b0));
    chk("drain_count", 64'(count), 64'(3'd0));
    chk("drain_state", 64'(state), 64'(2'd3));
    rd_ready = 1'b0;

    // Opcode trigger: opcode 1 fires on the capturing edge
    trig_op_en = 1'b1;
    trig_op = 3'd1;
    do_arm();
    do_fetch(13'h010, 3'd0, 13'h020, 8'h11);
    chk("op_nohit", 64'(state), 64'(2'd1));
    pc_addr = 13'h011; opcode = 3'd1; ir_addr = 13'h021; data = 8'h22;
    fetch = 1'b1;
    step();
    chk("op_trig_edge", 64'(state), 64'(2'd2));
    chk("op_trig_count", 64'(count), 64'(3'd2));
    fetch = 1'b0;
    step();
    do_fetch(13'h012, 3'd1, 13'h022, 8'h33);
    chk("op_ignored_post", 64'(state), 64'(2'd2));
    do_fetch(13'h013, 3'd5, 13'h023, 8'h44);
    chk("op_done", 64'(state), 64'(2'd3));
    chk("op_ovf", 64'(overflow), 64'(1'b0));
    expq[0] = mk(13'h010, 3'd0, 13'h020, 8'h11);
    expq[1] = mk(13'h011, 3'd1, 13'h021, 8'h22);
    expq[2] = mk(13'h012, 3'd1, 13'h022, 8'h33);
    expq[3] = mk(13'h013, 3'd5, 13'h023, 8'h44);
    // Paced readout: single-cycle rd_ready pulses
    for (int i = 0; i < 4; i++) begin
      chk("op_rd_entry", 64'(rd_entry), 64'(expq[i]));
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      chk("op_rd_count", 64'(count), 64'(3'(3 - i)));
      step();
    end
    trig_op_en = 1'b0;

    // Held fetch is one capture only
    do_arm();
    fetch = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
    end
    fetch = 1'b0;
    step();
    chk("held_count", 64'(count), 64'(3'd1));

    // arm coincident with a fetch edge in POST wins and records nothing
    halt_edge();
    chk("post_before_arm", 64'(state), 64'(2'd2));
    arm = 1'b1;
    fetch = 1'b1;
    step();
    chk("arm_prio_state", 64'(state), 64'(2'd1));
    chk("arm_prio_count", 64'(count), 64'(3'd0));
    arm = 1'b0;
    fetch = 1'b0;
    step();
    chk("arm_prio_count2", 64'(count), 64'(3'd0));
    chk("arm_prio_ovf", 64'(overflow), 64'(1'b0));

    // Asynchronous reset in the middle of POST
    do_fetch(13'h050, 3'd2, 13'h060, 8'h55);
    halt_edge();
    do_fetch(13'h051, 3'd3, 13'h061, 8'h66);
    chk("pre_reset_state", 64'(state), 64'(2'd2));
    chk("pre_reset_count", 64'(count), 64'(3'd2));
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_state", 64'(state), 64'(2'd0));
    chk("async_rst_count", 64'(count), 64'(3'd0));
    chk("async_rst_rdv", 64'(rd_valid), 64'(1'b0));
    #1;
    reset = 1'b0;
    step();
    chk("after_rst_idle", 64'(state), 64'(2'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 Parameter ADDR_W, default 13, width of pc_addr/ir_addr.
REQ-002 Parameter DATA_W, default 8, width of data bus sample.
REQ-003 Parameter OP_W, default 3, opcode width.
REQ-004 Parameter DEPTH, default 16, entry count; power of two, >=2.
REQ-005 Parameter POST_N, default 4, captures recorded after trigger; 0..DEPTH-1.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 arm  input  1  pulse: clear buffer, enter ARMED.
REQ-009 trig_op_en  input  1  enable opcode-match trigger.
REQ-010 trig_op  input  OP_W  opcode that fires trigger.
REQ-011 fetch  input  1  CPU fetch strobe; rising edge marks one instruction.
REQ-012 pc_addr  input  ADDR_W  program counter sample.
REQ-013 ir_addr  input  ADDR_W  instruction operand address sample.
REQ-014 opcode  input  OP_W  decoded opcode sample.
REQ-015 data  input  DATA_W  data bus sample.
REQ-016 halt  input  1  CPU halt; rising edge fires trigger.
REQ-017 rd_ready  input  1  consumer accepts rd_entry.
REQ-018 rd_valid  output  1  rd_entry holds oldest unread entry.
REQ-019 rd_entry  output  2*ADDR_W+OP_W+DATA_W  {pc_addr, opcode, ir_addr, data}, pc_addr in MSBs.
REQ-020 count  output  clog2(DEPTH)+1  entries held.
REQ-021 overflow  output  1  at least one entry overwritten since arm.
REQ-022 state  output  2  IDLE=0, ARMED=1, POST=2, DONE=3.

Function
REQ-023 Capture event: cycle with fetch=1 and registered previous fetch=0; only in ARMED or POST.
REQ-024 Capture writes input samples of that cycle at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-025 count increments per capture, saturates at DEPTH; capture at count=DEPTH overwrites oldest and sets overflow.
REQ-026 IDLE: no capture; arm -> ARMED.
REQ-027 arm in any state: wr_ptr, count, overflow cleared, next state ARMED; arm has priority over all other events in that cycle.
REQ-028 ARMED -> POST on halt rising edge, or capture with trig_op_en=1 and opcode=trig_op; post counter loaded with POST_N.
REQ-029 Trigger-cycle capture is recorded and does not decrement post counter.
REQ-030 POST: each capture decrements post counter; capture taking it to 0 -> DONE; POST_N=0 goes ARMED -> DONE directly on trigger.
REQ-031 Halt edge or opcode match in POST/DONE ignored.
REQ-032 DONE: rd_valid=1 iff count>0; rd_entry is entry at (wr_ptr-count) mod DEPTH, combinational from storage.
REQ-033 rd_valid&rd_ready pops one entry: count-1 next cycle; rd_valid low when count=0; state stays DONE until arm.
REQ-034 rd_valid=0 in IDLE, ARMED, POST; rd_ready ignored there.

Reset
REQ-035 reset forces state IDLE, wr_ptr=0, count=0, overflow=0, post counter=0, fetch edge register=0, halt edge register=0; rd_valid=0.
REQ-036 reset mid-capture or mid-readout discards all content; storage array need not be cleared.

Structure
REQ-037 State encoding and rd_entry field offsets live in shared package cpu_trace_pkg.
REQ-038 One sub-module trace_mem (DEPTH x entry register file, one write port, one async read port).

Verification
REQ-039 DEPTH=4, POST_N=2: arm, 3 fetches, halt edge, 2 fetches -> state DONE, count=4, overflow=1, first rd_entry = 2nd capture.
REQ-040 trig_op_en=1, trig_op=1 (SKZ): fetch with opcode 1 -> state POST same edge, trigger entry readable in order.
REQ-041 Readout with rd_ready held 1 -> one pop per cycle, entries oldest first, rd_valid falls after count reaches 0.
REQ-042 fetch held high 5 cycles -> exactly one capture.
REQ-043 arm asserted in POST coincident with fetch edge -> ARMED, count=0, no capture recorded.
REQ-044 reset asserted mid-POST asynchronously -> state=0, count=0 before next clk edge.
